fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Control-side partner of the ALU operand forwarding muxes in the 5-stage pipelined CPU.
- Shadows destination-register info through the ID/EX, EX/MEM and MEM/WB stages and drives the 2-bit forwarding selects for both ALU operands.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.
- Sits beside the pipeline registers and is fed from decode.

Parameters:
REG_AW, 5, register index width
CNT_W, 16, width of stall performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  ID stage holds a real instruction
id_rs_i  in  REG_AW  ID source register 1
id_rt_i  in  REG_AW  ID source register 2
id_rd_i  in  REG_AW  ID final destination (after RegDst selection)
id_regwrite_i  in  1  ID instruction writes register file
id_memread_i  in  1  ID instruction is a load
flush_i  in  1  branch taken; instruction in ID is discarded
fwd_a_o  out  2  operand A select: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result
fwd_b_o  out  2  operand B select, same encoding
stall_o  out  1  hold PC and IF/ID this cycle
stall_cnt_o  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Internal shadow stages EX, MEM, WB; each holds rs, rt, rd, regwrite, memread and valid (MEM/WB need only rd, regwrite, valid).
- Every rising edge: WB <= MEM; MEM <= EX; EX <= ID fields, or a bubble (valid=0, regwrite=0, memread=0) when stall_o=1 or flush_i=1.
- Reset (rst_i=1 at edge): all shadow valid/regwrite/memread bits = 0, stall_cnt_o = 0.
  - Consequently fwd_a_o = fwd_b_o = 00 and stall_o = 0 in the first cycle after reset.
  - Reset mid-stall drops the stall and the pending hazard.
- Forwarding is combinational from shadow state; selects are valid in the same cycle the instruction occupies EX.
- fwd_a_o:
  - 10 if MEM.valid & MEM.regwrite & MEM.rd != 0 & MEM.rd == EX.rs;
  - else 01 if WB.valid & WB.regwrite & WB.rd != 0 & WB.rd == EX.rs;
  - else 00.
  - EX/MEM has priority over MEM/WB when both match.
- fwd_b_o: identical rule against EX.rt.
- If EX.valid = 0 (bubble), both selects = 00.
- Register 0 is never forwarded.
- No forwarding into ID: a WB-stage write to a register read in ID is handled by the register file's write-first behaviour.
- stall_o = id_valid_i & EX.valid & EX.memread & EX.rd != 0 & (EX.rd == id_rs_i | EX.rd == id_rt_i) & ~flush_i.
  - Combinational, one cycle per load-use pair.
  - After the bubble, the load is in MEM and the dependent instruction gets 01 forwarding in EX.
- flush_i and hazard in the same cycle: flush wins; stall_o = 0 and a bubble enters EX.
- Back-to-back loads with chained dependency each produce their own single stall.
- stall_cnt_o increments on every edge where stall_o = 1 and rst_i = 0; it holds at all ones (no wrap).

Test Plan:
- Reset: hold rst_i for 2 cycles with id fields = add r3 (regwrite) -> fwd_a_o = fwd_b_o = 00, stall_o = 0, stall_cnt_o = 0, and no forwarding on the cycle after release.
- EX/MEM forward: add r3 then sub r5, r3, r4 -> in sub's EX cycle fwd_a_o = 10, fwd_b_o = 00.
- MEM/WB forward and priority:
  - add r3; nop; and r6, r4, r3 -> fwd_b_o = 01.
  - add r3; add r3; or r7, r3, r3 -> fwd_a_o = fwd_b_o = 10.
- Load-use: lw r2 then add r4, r2, r2 -> stall_o = 1 for exactly one cycle, a bubble enters EX, then add in EX gets fwd_a_o = fwd_b_o = 01; stall_cnt_o = 1.
- Register zero and flush:
  - add r0 then sub r5, r0, r0 -> selects 00.
  - lw r2 followed by dependent add with flush_i = 1 -> stall_o = 0, stall_cnt_o unchanged.
- Counter saturation: force 2^CNT_W + 3 stall cycles -> stall_cnt_o = all ones, no wrap; rst_i then clears it to 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side bus between the pipeline and the forwarding/hazard controller
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding selects and load-use stall for a 5-stage pipeline
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fwd_hazard_ctrl_if.slave   bus
);
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic              ex_valid_q,    ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    logic [REG_AW-1:0] ex_rs_q,       ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,       ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;

    logic              mem_valid_q,    mem_valid_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    logic [REG_AW-1:0] mem_rd_q,       mem_rd_d;

    logic              wb_valid_q,    wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic [REG_AW-1:0] wb_rd_q,       wb_rd_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic stall;
    logic bubble;

    // EX/MEM result is younger than MEM/WB, so it wins when both write the same register.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_valid_q) begin
            if (mem_valid_q && mem_regwrite_q && (mem_rd_q != REG_ZERO) && (mem_rd_q == src)) begin
                sel = 2'b10;
            end else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != REG_ZERO) && (wb_rd_q == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        stall = bus.id_valid_i && ex_valid_q && ex_memread_q && (ex_rd_q != REG_ZERO)
                && ((ex_rd_q == bus.id_rs_i) || (ex_rd_q == bus.id_rt_i)) && !bus.flush_i;
        bubble = stall || bus.flush_i;

        ex_valid_d    = bus.id_valid_i && !bubble;
        ex_regwrite_d = bus.id_regwrite_i && !bubble;
        ex_memread_d  = bus.id_memread_i && !bubble;
        ex_rs_d       = bus.id_rs_i;
        ex_rt_d       = bus.id_rt_i;
        ex_rd_d       = bus.id_rd_i;

        mem_valid_d    = ex_valid_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_rd_d       = ex_rd_q;

        wb_valid_d    = mem_valid_q;
        wb_regwrite_d = mem_regwrite_q;
        wb_rd_d       = mem_rd_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= mem_valid_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_rd_q       <= mem_rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_rd_q        <= wb_rd_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign bus.fwd_a_o     = fwd_sel(ex_rs_q);
    assign bus.fwd_b_o     = fwd_sel(ex_rt_q);
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } instr_t;

    logic clk;
    logic rst;
    int   chk;
    int   err;

    instr_t older[$];
    int     m_cnt;

    fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t nop_i();
        instr_t n;
        n.v = 0; n.rs = 0; n.rt = 0; n.rd = 0; n.rw = 0; n.mr = 0;
        return n;
    endfunction

    // older[0] is the instruction in EX, older[1] in MEM, older[2] in WB.
    function automatic bit m_stall();
        instr_t e;
        e = older[0];
        return bus.id_valid_i && e.v && e.mr && e.rd != 0
               && (e.rd == bus.id_rs_i || e.rd == bus.id_rt_i) && !bus.flush_i;
    endfunction

    function automatic bit [1:0] m_fwd(input bit use_rt);
        bit [4:0] src;
        if (!older[0].v) return 2'b00;
        src = use_rt ? older[0].rt : older[0].rs;
        for (int k = 1; k <= 2; k++) begin
            if (older[k].v && older[k].rw && older[k].rd != 0 && older[k].rd == src)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input int rd,
                         input bit rw, input bit mr, input bit fl);
        bus.id_valid_i    = v;
        bus.id_rs_i       = 5'(rs);
        bus.id_rt_i       = 5'(rt);
        bus.id_rd_i       = 5'(rd);
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.flush_i       = fl;
        #1;
    endtask

    task automatic tick();
        bit     st;
        bit     r;
        instr_t id;
        st = m_stall();
        r  = rst;
        id.v = bus.id_valid_i; id.rs = bus.id_rs_i; id.rt = bus.id_rt_i;
        id.rd = bus.id_rd_i; id.rw = bus.id_regwrite_i; id.mr = bus.id_memread_i;
        @(posedge clk);
        if (r) begin
            older = '{nop_i(), nop_i(), nop_i()};
            m_cnt = 0;
        end else begin
            if (st && m_cnt < CMAX) m_cnt++;
            void'(older.pop_back());
            older.push_front((st || bus.flush_i) ? nop_i() : id);
        end
        #1;
    endtask

    task automatic issue(input int rs, input int rt, input int rd, input bit rw, input bit mr);
        drive(1, rs, rt, rd, rw, mr, 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(1, 1, 2, 3, 1, 0, 0);
        tick();
        tick();
        chk++; if (bus.fwd_a_o !== 2'b00) begin err++; $display("FAIL reset_fwd_a got %b want 00", bus.fwd_a_o); end
        chk++; if (bus.fwd_b_o !== 2'b00) begin err++; $display("FAIL reset_fwd_b got %b want 00", bus.fwd_b_o); end
        chk++; if (bus.stall_o !== 1'b0) begin err++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
        chk++; if (bus.stall_cnt_o !== '0) begin err++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt_o); end
        rst = 0;
        drive(1, 3, 3, 5, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            err++; $display("FAIL post_reset_fwd got %b/%b want 00/00", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_ex_mem_fwd();
        do_reset();
        issue(1, 2, 3, 1, 0);
        issue(3, 4, 5, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_a_o !== 2'b10) begin err++; $display("FAIL exmem_fwd_a got %b want 10", bus.fwd_a_o); end
        chk++; if (bus.fwd_b_o !== 2'b00) begin err++; $display("FAIL exmem_fwd_b got %b want 00", bus.fwd_b_o); end
    endtask

    task automatic test_mem_wb_fwd();
        do_reset();
        issue(1, 2, 3, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        issue(4, 3, 6, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_b_o !== 2'b01) begin err++; $display("FAIL memwb_fwd_b got %b want 01", bus.fwd_b_o); end
        chk++; if (bus.fwd_a_o !== 2'b00) begin err++; $display("FAIL memwb_fwd_a got %b want 00", bus.fwd_a_o); end
    endtask

    task automatic test_priority();
        do_reset();
        issue(1, 2, 3, 1, 0);
        issue(1, 2, 3, 1, 0);
        issue(3, 3, 7, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_a_o !== 2'b10 || bus.fwd_b_o !== 2'b10) begin
            err++; $display("FAIL priority_fwd got %b/%b want 10/10", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 2, 2, 1, 1);
        drive(1, 2, 2, 4, 1, 0, 0);
        chk++; if (bus.stall_o !== 1'b1) begin err++; $display("FAIL loaduse_stall got %b want 1", bus.stall_o); end
        tick();
        chk++; if (bus.stall_o !== 1'b0) begin err++; $display("FAIL loaduse_stall_once got %b want 0", bus.stall_o); end
        chk++; if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            err++; $display("FAIL loaduse_bubble got %b/%b want 00/00", bus.fwd_a_o, bus.fwd_b_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_a_o !== 2'b01 || bus.fwd_b_o !== 2'b01) begin
            err++; $display("FAIL loaduse_fwd got %b/%b want 01/01", bus.fwd_a_o, bus.fwd_b_o);
        end
        chk++; if (bus.stall_cnt_o !== CNT_W'(1)) begin err++; $display("FAIL loaduse_cnt got %0d want 1", bus.stall_cnt_o); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        issue(1, 2, 0, 1, 0);
        issue(0, 0, 5, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            err++; $display("FAIL regzero_fwd got %b/%b want 00/00", bus.fwd_a_o, bus.fwd_b_o);
        end
        do_reset();
        issue(1, 0, 0, 1, 1);
        drive(1, 0, 0, 4, 1, 0, 0);
        chk++; if (bus.stall_o !== 1'b0) begin err++; $display("FAIL regzero_stall got %b want 0", bus.stall_o); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 2, 2, 1, 1);
        drive(1, 2, 2, 4, 1, 0, 1);
        chk++; if (bus.stall_o !== 1'b0) begin err++; $display("FAIL flush_stall got %b want 0", bus.stall_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.stall_cnt_o !== '0) begin err++; $display("FAIL flush_cnt got %0d want 0", bus.stall_cnt_o); end
        chk++; if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            err++; $display("FAIL flush_bubble got %b/%b want 00/00", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(1, 0, 2, 1, 1);
        drive(1, 2, 0, 3, 1, 1, 0);
        chk++; if (bus.stall_o !== 1'b1) begin err++; $display("FAIL b2b_stall1 got %b want 1", bus.stall_o); end
        tick();
        tick();
        drive(1, 3, 0, 4, 1, 0, 0);
        chk++; if (bus.stall_o !== 1'b1) begin err++; $display("FAIL b2b_stall2 got %b want 1", bus.stall_o); end
        chk++; if (bus.fwd_a_o !== 2'b01) begin err++; $display("FAIL b2b_fwd_a got %b want 01", bus.fwd_a_o); end
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.stall_cnt_o !== CNT_W'(2)) begin err++; $display("FAIL b2b_cnt got %0d want 2", bus.stall_cnt_o); end
        chk++; if (bus.fwd_a_o !== 2'b01) begin err++; $display("FAIL b2b_fwd_dep got %b want 01", bus.fwd_a_o); end
    endtask

    task automatic test_random();
        bit hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (hold) begin
                #1;
            end else begin
                drive($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 7) == 0);
            end
            chk++; if (bus.fwd_a_o !== m_fwd(0) || bus.fwd_b_o !== m_fwd(1)
                       || bus.stall_o !== m_stall() || bus.stall_cnt_o !== CNT_W'(m_cnt)) begin
                err++;
                $display("FAIL random_cyc%0d got a=%b b=%b st=%b cnt=%0d want a=%b b=%b st=%b cnt=%0d",
                         i, bus.fwd_a_o, bus.fwd_b_o, bus.stall_o, bus.stall_cnt_o,
                         m_fwd(0), m_fwd(1), m_stall(), m_cnt);
            end
            hold = m_stall() && !rst;
            tick();
        end
        rst = 0;
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        n = 0;
        drive(1, 2, 0, 2, 1, 1, 0);
        for (int i = 0; i < 2 * (CMAX + 4) + 2; i++) begin
            if (m_stall()) n++;
            tick();
        end
        chk++; if (n < CMAX + 4) begin err++; $display("FAIL sat_stall_cycles got %0d want >= %0d", n, CMAX + 4); end
        chk++; if (bus.stall_cnt_o !== CNT_W'(CMAX)) begin
            err++; $display("FAIL sat_cnt got %0d want %0d", bus.stall_cnt_o, CMAX);
        end
        rst = 1;
        tick();
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk++; if (bus.stall_cnt_o !== '0) begin err++; $display("FAIL sat_reset_cnt got %0d want 0", bus.stall_cnt_o); end
    endtask

    initial begin
        chk = 0;
        err = 0;
        m_cnt = 0;
        older = '{nop_i(), nop_i(), nop_i()};
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ex_mem_fwd();
        test_mem_wb_fwd();
        test_priority();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
